// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the arbiter, its two requesters (core, debug) and the data RAM.
// slave is the arbiter's view; master is the view of everything around it.
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_W = 32
);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  // core load/store path
  logic              core_req;
  logic              core_wr_en;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wr_data;
  logic [BE_W-1:0]   core_byte_en;
  logic              core_stall;
  logic [DATA_W-1:0] core_rd_data;
  logic              core_rd_valid;

  // debug/loader master
  logic              dbg_req;
  logic              dbg_wr_en;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wr_data;
  logic              dbg_gnt;
  logic [DATA_W-1:0] dbg_rd_data;
  logic              dbg_rd_valid;
  logic              dbg_halt_req;
  logic              dbg_halt_ack;

  // synchronous data RAM
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic [BE_W-1:0]   mem_wr_en;
  logic              mem_rd_en;
  logic [DATA_W-1:0] mem_rd_data;

  modport slave (
    input  core_req, core_wr_en, core_addr, core_wr_data, core_byte_en,
    output core_stall, core_rd_data, core_rd_valid,
    input  dbg_req, dbg_wr_en, dbg_addr, dbg_wr_data, dbg_halt_req,
    output dbg_gnt, dbg_rd_data, dbg_rd_valid, dbg_halt_ack,
    output mem_addr, mem_wr_data, mem_wr_en, mem_rd_en,
    input  mem_rd_data
  );

  modport master (
    output core_req, core_wr_en, core_addr, core_wr_data, core_byte_en,
    input  core_stall, core_rd_data, core_rd_valid,
    output dbg_req, dbg_wr_en, dbg_addr, dbg_wr_data, dbg_halt_req,
    input  dbg_gnt, dbg_rd_data, dbg_rd_valid, dbg_halt_ack,
    input  mem_addr, mem_wr_data, mem_wr_en, mem_rd_en,
    output mem_rd_data
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: core has priority, debug is protected from starvation
// by a refusal counter and can take exclusive ownership through a halt handshake.
// At most one RAM access per cycle; read data is steered to whoever issued the read.
module dmem_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DBG_MAX_WAIT = 8
) (
  input logic           Clk,
  input logic           Reset,
  dmem_arbiter_if.slave bus
);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned WAIT_W = $clog2(DBG_MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(DBG_MAX_WAIT);
  localparam logic [BE_W-1:0]   BE_FULL  = {BE_W{1'b1}};

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_HALT_PEND = 2'd1,
    ST_HALTED    = 2'd2
  } halt_state_e;

  halt_state_e       state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              core_rd_pend;
  logic              dbg_rd_pend;
  logic              halt_ack;

  logic              core_win_c;
  logic              dbg_win_c;
  logic [ADDR_W-1:0] addr_sel_c;
  logic [DATA_W-1:0] wdata_sel_c;
  logic [BE_W-1:0]   wr_en_sel_c;
  logic              rd_en_sel_c;

  // Pick this cycle's winner: halt locks the core out, a starved debug beats the core.
  always_comb begin
    core_win_c = 1'b0;
    dbg_win_c  = 1'b0;
    if (state != ST_RUN) begin
      dbg_win_c = bus.dbg_req;
    end else if (bus.dbg_req && (wait_cnt == WAIT_MAX)) begin
      dbg_win_c = 1'b1;
    end else if (bus.core_req) begin
      core_win_c = 1'b1;
    end else begin
      dbg_win_c = bus.dbg_req;
    end
  end

  // Steer the winner onto the RAM port; with no winner the core inputs pass through idle.
  always_comb begin
    addr_sel_c  = bus.core_addr;
    wdata_sel_c = bus.core_wr_data;
    wr_en_sel_c = '0;
    rd_en_sel_c = 1'b0;
    if (core_win_c) begin
      wr_en_sel_c = bus.core_wr_en ? bus.core_byte_en : '0;
      rd_en_sel_c = !bus.core_wr_en;
    end else if (dbg_win_c) begin
      addr_sel_c  = bus.dbg_addr;
      wdata_sel_c = bus.dbg_wr_data;
      wr_en_sel_c = bus.dbg_wr_en ? BE_FULL : '0;
      rd_en_sel_c = !bus.dbg_wr_en;
    end
  end

  // Handshake and RAM-side outputs.
  always_comb begin
    bus.core_stall    = bus.core_req && !core_win_c;
    bus.dbg_gnt       = dbg_win_c;
    bus.mem_addr      = addr_sel_c;
    bus.mem_wr_data   = wdata_sel_c;
    bus.mem_wr_en     = wr_en_sel_c;
    bus.mem_rd_en     = rd_en_sel_c;
    bus.core_rd_data  = bus.mem_rd_data;
    bus.dbg_rd_data   = bus.mem_rd_data;
    bus.core_rd_valid = core_rd_pend;
    bus.dbg_rd_valid  = dbg_rd_pend;
    bus.dbg_halt_ack  = halt_ack;
  end

  // Debug refusal counter: cleared on grant or when debug is idle, saturates at the limit.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wait_cnt <= '0;
    end else if (dbg_win_c || !bus.dbg_req) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WAIT_MAX) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  // Read-return tracking: a valid fires exactly one cycle after its owner's read won.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      core_rd_pend <= 1'b0;
      dbg_rd_pend  <= 1'b0;
    end else begin
      core_rd_pend <= core_win_c && !bus.core_wr_en;
      dbg_rd_pend  <= dbg_win_c && !bus.dbg_wr_en;
    end
  end

  // Halt FSM; HALTED is entered only once no core read is still returning.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= ST_RUN;
      halt_ack <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (bus.dbg_halt_req) begin
            state <= ST_HALT_PEND;
          end
        end
        ST_HALT_PEND: begin
          if (!bus.dbg_halt_req) begin
            state <= ST_RUN;
          end else if (!core_rd_pend) begin
            state    <= ST_HALTED;
            halt_ack <= 1'b1;
          end
        end
        ST_HALTED: begin
          if (!bus.dbg_halt_req) begin
            state    <= ST_RUN;
            halt_ack <= 1'b0;
          end
        end
        default: begin
          state    <= ST_RUN;
          halt_ack <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios followed by random traffic, every cycle
// compared against a rule-level reference model and a behavioural RAM.
module tb_dmem_arbiter;
  localparam int unsigned MAX_WAIT = 8;
  localparam int unsigned NWORDS   = 64;

  logic Clk = 1'b0;
  logic Reset;

  dmem_arbiter_if #(.ADDR_W(32)) bus ();

  dmem_arbiter #(.ADDR_W(32), .DBG_MAX_WAIT(MAX_WAIT)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  // behavioural synchronous RAM seen by the DUT
  logic [31:0] ram [NWORDS];
  always @(posedge Clk) begin
    if (bus.mem_rd_en) bus.mem_rd_data <= ram[bus.mem_addr[7:2]];
    for (int b = 0; b < 4; b++)
      if (bus.mem_wr_en[b]) ram[bus.mem_addr[7:2]][8*b +: 8] <= bus.mem_wr_data[8*b +: 8];
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
  endtask

  // reference model state
  logic [31:0] mdl_mem [NWORDS];
  int          mode;        // 0 running, 1 halt requested, 2 halted
  int          wcnt;        // consecutive debug refusals
  bit          exp_cv, exp_dv;
  logic [31:0] exp_rd;
  bit          mdl_known = 0;

  // stimulus for the next cycle
  bit          s_rst, s_creq, s_cwr, s_dreq, s_dwr, s_halt;
  logic [31:0] s_caddr, s_cwd, s_daddr, s_dwd;
  logic [3:0]  s_cbe;

  task automatic idle();
    s_rst = 0; s_creq = 0; s_cwr = 0; s_dreq = 0; s_dwr = 0;
  endtask

  // One clock: check returned state, apply stimulus, check the same-cycle decision, advance model.
  task automatic step();
    bit          cwin, dwin, ncv, ndv;
    logic [31:0] e_addr, e_wd, nrd;
    logic [3:0]  e_we;
    bit          e_re;
    logic [5:0]  idx;
    @(negedge Clk);
    if (mdl_known) begin
      check("core_rd_valid", 32'(bus.core_rd_valid), 32'(exp_cv));
      check("dbg_rd_valid", 32'(bus.dbg_rd_valid), 32'(exp_dv));
      check("dbg_halt_ack", 32'(bus.dbg_halt_ack), 32'(mode == 2));
      if (exp_cv) check("core_rd_data", bus.core_rd_data, exp_rd);
      if (exp_dv) check("dbg_rd_data", bus.dbg_rd_data, exp_rd);
    end
    Reset = s_rst;
    bus.core_req = s_creq; bus.core_wr_en = s_cwr; bus.core_addr = s_caddr;
    bus.core_wr_data = s_cwd; bus.core_byte_en = s_cbe;
    bus.dbg_req = s_dreq; bus.dbg_wr_en = s_dwr; bus.dbg_addr = s_daddr;
    bus.dbg_wr_data = s_dwd; bus.dbg_halt_req = s_halt;
    #1;
    // who gets the port under the priority rules
    if (mode != 0)                             begin cwin = 0;      dwin = s_dreq; end
    else if (s_dreq && wcnt >= int'(MAX_WAIT)) begin cwin = 0;      dwin = 1;      end
    else                                       begin cwin = s_creq; dwin = s_dreq && !s_creq; end
    e_addr = s_caddr; e_wd = s_cwd; e_we = 4'h0; e_re = 0;
    if (cwin) begin
      e_re = !s_cwr; e_we = s_cwr ? s_cbe : 4'h0;
    end else if (dwin) begin
      e_addr = s_daddr; e_wd = s_dwd; e_re = !s_dwr; e_we = s_dwr ? 4'hF : 4'h0;
    end
    if (mdl_known) begin
      check("core_stall", 32'(bus.core_stall), 32'(s_creq && !cwin));
      check("dbg_gnt", 32'(bus.dbg_gnt), 32'(dwin));
      check("mem_rd_en", 32'(bus.mem_rd_en), 32'(e_re));
      check("mem_wr_en", 32'(bus.mem_wr_en), 32'(e_we));
      check("mem_addr", bus.mem_addr, e_addr);
      check("mem_wr_data", bus.mem_wr_data, e_wd);
    end
    // memory contents and read return
    idx = e_addr[7:2];
    nrd = mdl_mem[idx];
    for (int b = 0; b < 4; b++) if (e_we[b]) mdl_mem[idx][8*b +: 8] = e_wd[8*b +: 8];
    ncv = cwin && !s_cwr;
    ndv = dwin && !s_dwr;
    // refusal counter
    if (dwin || !s_dreq) wcnt = 0;
    else if (wcnt < int'(MAX_WAIT)) wcnt++;
    // halt handshake, using whether a core read is returning this cycle
    case (mode)
      0: if (s_halt) mode = 1;
      1: if (!s_halt) mode = 0; else if (!exp_cv) mode = 2;
      default: if (!s_halt) mode = 0;
    endcase
    exp_cv = ncv; exp_dv = ndv; exp_rd = nrd;
    if (s_rst) begin
      mode = 0; wcnt = 0; exp_cv = 0; exp_dv = 0; mdl_known = 1;
    end
  endtask

  initial begin
    for (int i = 0; i < int'(NWORDS); i++) begin
      ram[i]     = 32'h5A5A_0000 ^ (32'(i) * 32'h0101_0101);
      mdl_mem[i] = ram[i];
    end
    ram[16] = 32'hDEAD_BEEF; mdl_mem[16] = 32'hDEAD_BEEF;
    bus.mem_rd_data = '0;
    s_caddr = 0; s_cwd = 0; s_cbe = 0; s_daddr = 0; s_dwd = 0; s_halt = 0;
    idle();
    s_rst = 1; step(); step();
    idle(); step();

    // core load of 0x40
    s_creq = 1; s_caddr = 32'h40; step();
    idle(); step(); step();

    // core saturating the port, debug must break through after MAX_WAIT refusals
    s_creq = 1; s_caddr = 32'h44; s_dreq = 1; s_daddr = 32'h48;
    for (int i = 0; i < 12; i++) step();
    idle(); step();

    // core byte store collides with a debug read: core wins
    s_creq = 1; s_cwr = 1; s_cbe = 4'b0100; s_caddr = 32'h40; s_cwd = 32'h00AB_0000;
    s_dreq = 1; s_daddr = 32'h40; step();
    idle(); s_dreq = 1; s_daddr = 32'h40; step();
    idle(); step();

    // halt requested right after a core read is granted
    s_creq = 1; s_caddr = 32'h40; step();
    s_halt = 1; step(); step(); step(); step();
    // exclusive debug access while halted
    s_dreq = 1; s_dwr = 1; s_daddr = 32'h80; s_dwd = 32'h1234_5678; step();
    s_dwr = 0; step();
    s_dreq = 0; step();
    s_halt = 0; step(); step();
    idle(); step();

    // reset lands while a debug read is returning
    s_dreq = 1; s_daddr = 32'h80; step();
    idle(); s_rst = 1; step();
    idle(); step(); step();

    // random traffic with occasional halts and resets
    for (int i = 0; i < 3000; i++) begin
      s_rst   = ($urandom_range(0, 255) == 0);
      s_creq  = ($urandom_range(0, 3) != 0);
      s_cwr   = $urandom_range(0, 1) != 0;
      s_caddr = $urandom;
      s_cwd   = $urandom;
      s_cbe   = 4'($urandom_range(0, 15));
      s_dreq  = $urandom_range(0, 1) != 0;
      s_dwr   = $urandom_range(0, 1) != 0;
      s_daddr = $urandom;
      s_dwd   = $urandom;
      if ($urandom_range(0, 15) == 0) s_halt = !s_halt;
      step();
    end
    idle(); s_halt = 0; step(); step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
